// File: rtl/mem_pkg.sv
// Shared memory-port constants, fetch FSM states
// and the fetch buffer entry layout.
package mem_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] START_ADDR = 32'h0100_0000;
  localparam int unsigned MEM_DEPTH_BYTES = 'h0100000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, word}
// entries with wrap-bit pointers and a flush input.
module fetch_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_count
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  fetch_entry_t r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_count   = r_wptr - r_rptr;
  assign o_full    = (o_count == LP_DEPTH);
  assign o_empty   = (r_wptr == r_rptr);
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
  assign w_do_push = i_push & ~i_clear
                   & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  // Pointer update; a flush empties the buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push)
        r_wptr <= r_wptr + LP_ONE;
      if (w_do_pop)
        r_rptr <= r_rptr + LP_ONE;
    end
  end

  // Entry storage, written at the tail on push
  always_ff @(posedge clock) begin
    if (w_do_push)
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch: PC register, fetch FSM,
// redirect handling and a small buffer toward decode.
module fetch_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = mem_pkg::START_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data_out,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH =
    (AW+1)'(FIFO_DEPTH);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_hold_insn;
  logic [31:0]  r_hold_pc;

  fetch_entry_t w_wdata;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;
  logic [AW:0]  w_next_count;
  logic         w_push;
  logic         w_pop;
  logic         w_will_full;

  assign w_pop  = ~w_empty & insn_ready
                & ~redirect_valid;
  assign w_push = (r_state == FETCH)
                & ~redirect_valid
                & (~w_full | w_pop);

  assign w_next_count = w_count
                      + {{AW{1'b0}}, w_push}
                      - {{AW{1'b0}}, w_pop};
  assign w_will_full  = (w_next_count == LP_DEPTH);

  assign w_wdata.pc   = r_pc;
  assign w_wdata.word = mem_data_out;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign mem_address    = r_pc;
  assign mem_data_in    = '0;
  assign mem_read_write = READ;

  assign insn_valid = ~w_empty;
  assign insn    = insn_valid ? w_head.word
                              : r_hold_insn;
  assign insn_pc = insn_valid ? w_head.pc
                              : r_hold_pc;

  // Remember the presented head so it holds when empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_insn <= '0;
      r_hold_pc   <= '0;
    end else begin
      r_hold_insn <= insn;
      r_hold_pc   <= insn_pc;
    end
  end

  // Fetch FSM and PC; redirect overrides push and pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= START_ADDR;
    end else if (redirect_valid) begin
      r_state <= run ? FETCH : IDLE;
      r_pc    <= word_align(redirect_pc);
    end else begin
      if (w_push)
        r_pc <= r_pc + 32'd4;
      unique case (r_state)
        IDLE: begin
          if (run)
            r_state <= FETCH;
        end
        FETCH: begin
          if (!run)
            r_state <= IDLE;
          else if (w_will_full)
            r_state <= STALL;
        end
        STALL: begin
          if (w_pop)
            r_state <= FETCH;
          else if (!run && w_full)
            r_state <= IDLE;
          else if (!run)
            r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational
// memory model and hand-computed expected values.
module tb_fetch_unit;
  import mem_pkg::*;

  logic        clock;
  logic        reset;
  logic        run;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_read_write;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pre [4] = '{
    32'h1111_0000, 32'h2222_0004,
    32'h3333_0008, 32'h4444_000C
  };

  function automatic logic [31:0] memw(
    input logic [31:0] a
  );
    if (a >= 32'h0100_0000 && a < 32'h0100_0010)
      return pre[a[3:2]];
    return a ^ 32'h1357_9BDF;
  endfunction

  assign mem_data_out = memw(mem_address);

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .mem_address    (mem_address),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in),
    .mem_read_write (mem_read_write),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    run = 1'b0;
    insn_ready = 1'b0;
    redirect_valid = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("rw", 32'(mem_read_write), 32'(READ));
      check("wdata", mem_data_in, 32'h0);
    end
  end

  initial begin
    reset = 1'b1;
    run = 1'b0;
    insn_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_valid", 32'(insn_valid), 32'h0);
    check("rst_insn", insn, 32'h0);
    check("rst_pc", insn_pc, 32'h0);
    check("rst_addr", mem_address, 32'h0100_0000);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));

    // streaming with decode always ready
    run = 1'b1;
    insn_ready = 1'b1;
    step();
    check("t1_novalid", 32'(insn_valid), 32'h0);
    check("t1_state", 32'(dut.r_state), 32'(FETCH));
    step();
    check("t1_valid", 32'(insn_valid), 32'h1);
    check("t1_pc0", insn_pc, 32'h0100_0000);
    check("t1_w0", insn, 32'h1111_0000);
    step();
    check("t1_pc1", insn_pc, 32'h0100_0004);
    check("t1_w1", insn, 32'h2222_0004);
    step();
    check("t1_pc2", insn_pc, 32'h0100_0008);
    check("t1_w2", insn, 32'h3333_0008);
    step();
    check("t1_pc3", insn_pc, 32'h0100_000C);
    check("t1_w3", insn, 32'h4444_000C);

    // decode stalled: buffer fills, fetch stops
    pulse_reset();
    run = 1'b1;
    step();
    repeat (4) step();
    check("t2_addr", mem_address, 32'h0100_0010);
    check("t2_state", 32'(dut.r_state), 32'(STALL));
    step();
    check("t2_freeze", mem_address, 32'h0100_0010);
    check("t2_head", insn_pc, 32'h0100_0000);
    check("t2_hword", insn, 32'h1111_0000);
    insn_ready = 1'b1;
    step();
    check("t2_d1", insn_pc, 32'h0100_0004);
    step();
    check("t2_d2", insn_pc, 32'h0100_0008);
    step();
    check("t2_d3", insn_pc, 32'h0100_000C);
    step();
    check("t2_d4", insn_pc, 32'h0100_0010);
    check("t2_d4w", insn, 32'h0100_0010 ^ 32'h1357_9BDF);
    step();
    check("t2_d5", insn_pc, 32'h0100_0014);

    // redirect with 3 buffered and a pop requested
    pulse_reset();
    run = 1'b1;
    step();
    repeat (3) step();
    check("t3_addr", mem_address, 32'h0100_000C);
    check("t3_head", insn_pc, 32'h0100_0000);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0023;
    insn_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("t3_flush", 32'(insn_valid), 32'h0);
    check("t3_hold", insn_pc, 32'h0100_0000);
    check("t3_raddr", mem_address, 32'h0100_0020);
    step();
    check("t3_valid", 32'(insn_valid), 32'h1);
    check("t3_pc", insn_pc, 32'h0100_0020);
    check("t3_word", insn, 32'h1257_9BFF);

    // redirect to the top word, PC wraps to 0
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("t4_flush", 32'(insn_valid), 32'h0);
    check("t4_raddr", mem_address, 32'hFFFF_FFFC);
    step();
    check("t4_pc0", insn_pc, 32'hFFFF_FFFC);
    check("t4_w0", insn, 32'hECA8_6423);
    step();
    check("t4_pc1", insn_pc, 32'h0000_0000);
    check("t4_w1", insn, 32'h1357_9BDF);
    check("t4_addr", mem_address, 32'h0000_0004);

    // asynchronous reset while stalled and full
    pulse_reset();
    run = 1'b1;
    step();
    repeat (4) step();
    check("t5_stall", 32'(dut.r_state), 32'(STALL));
    check("t5_full", 32'(insn_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t5_valid", 32'(insn_valid), 32'h0);
    check("t5_addr", mem_address, 32'h0100_0000);
    check("t5_state", 32'(dut.r_state), 32'(IDLE));
    check("t5_insn", insn, 32'h0);
    #1 reset = 1'b0;
    run = 1'b0;
    step();
    step();
    check("t5_idle", 32'(insn_valid), 32'h0);
    check("t5_idleaddr", mem_address, 32'h0100_0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
